inert_cmd_seq: RTL
==================

Name: inert_cmd_seq

Overview:
- Command sequencer that sits directly upstream of the SPI monarch and consumes its read data.
- After reset it configures the inertial sensor with three register writes.
- It then services every data-ready interrupt by reading the yaw-rate low and high bytes, and presents a signed 16-bit yaw rate with a one-cycle valid strobe to downstream heading logic.

Parameters:
- FAST_SIM, 1'b0, when 1 the power-up wait terminates when timer[8:0] is all ones instead of timer[15:0] (simulation speedup).

Ports:
- clk  input  1  system clock, 50MHz
- rst_n  input  1  reset, asynchronous, active-low
- INT  input  1  sensor data-ready interrupt, asynchronous to clk, active high
- done  input  1  SPI monarch done level (set at transaction end, cleared by wrt)
- rd_data  input  16  SPI monarch read data; only [7:0] is meaningful
- wrt  output  1  one-cycle pulse starting an SPI transaction
- cmd  output  16  command word to SPI monarch wt_data
- yaw_rt  output  16  signed yaw rate {high byte, low byte}
- vld  output  1  one-cycle strobe, yaw_rt updated this cycle
- cfg_done  output  1  level, high once all three config writes have completed

Behaviour:
- Reset values: wrt=0, vld=0, cfg_done=0, yaw_rt=16'h0000, timer=0, INT synchronizer flops=0, state=PWR_WAIT.
- cmd is combinational from state and is valid in the wrt cycle. Outside defined states it is 16'h0000.
- INT passes through a 2-flop synchronizer (INT_s). The FSM uses only INT_s.
- A 16-bit timer free-runs from reset. It only matters in PWR_WAIT.
- Handshake: wrt is asserted for exactly one cycle, on the cycle the FSM leaves an issue state. The FSM then sits in the paired wait state until done==1.
  - done is a level, cleared by the monarch on the edge after wrt. The wait state is therefore never evaluated with stale done.
- States and transitions:
  - PWR_WAIT: when timer all ones (or [8:0] all ones if FAST_SIM) -> W1 with wrt=1, cmd=16'h0D02 (INT on gyro data ready).
  - W1: wait done -> W2 with wrt=1, cmd=16'h1160 (gyro ODR 416Hz).
  - W2: wait done -> W3 with wrt=1, cmd=16'h1440 (gyro rounding).
  - W3: wait done -> IDLE; set cfg_done=1 (sticky until reset).
  - IDLE: if INT_s -> RDL with wrt=1, cmd=16'hA600 (read yaw low).
  - RDL: wait done -> capture rd_data[7:0] into yaw_lo holding reg; -> RDH with wrt=1, cmd=16'hA700 (read yaw high).
  - RDH: wait done -> yaw_rt <= {rd_data[7:0], yaw_lo}; vld=1 for that cycle; -> IDLE.
- INT handling: the sensor drops INT when the yaw low byte is read. The RDH transaction exceeds 256 clocks, so INT_s is low on return to IDLE and no spurious re-read occurs.
  - If INT is still high on return to IDLE (a new sample is ready), an immediate new read is correct behaviour.
- INT asserted during the configuration states (PWR_WAIT..W3) is ignored. It is serviced on reaching IDLE if still high.
- yaw_rt holds its value between vld strobes. yaw_lo is not visible outside the block.
- A stray done while in PWR_WAIT or IDLE has no effect.
- Reset mid-transaction: immediate return to PWR_WAIT. The whole configuration sequence reruns.

Decomposition:
- Shared package inert_pkg:
  - state enum (PWR_WAIT, W1, W2, W3, IDLE, RDL, RDH)
  - command localparams CMD_INT_EN=16'h0D02, CMD_GYRO_ODR=16'h1160, CMD_GYRO_RND=16'h1440, CMD_YAWL=16'hA600, CMD_YAWH=16'hA700
- Optional sub-module sync2 for the 2-flop INT synchronizer. Everything else stays flat.

Test Plan:
- Power-up with FAST_SIM=1, bench SPI model returns done 300 cycles after each wrt -> wrt pulses carry cmd 0x0D02, 0x1160, 0x1440 in order; first wrt 512 cycles after reset; cfg_done rises after the third done.
- Cfg complete, INT pulsed high, model returns rd_data=0x00C5 then 0x00FF and drops INT after the first read -> cmds 0xA600, 0xA700; one vld; yaw_rt=16'hFFC5 (-59).
- INT held high across a full read cycle -> second read sequence starts within 2 cycles of returning to IDLE; two vld strobes, each one cycle wide.
- INT asserted during W2 -> no read command until cfg_done=1, then 0xA600 issued.
- rst_n asserted while in RDH -> wrt=0, vld=0, yaw_rt=0, cfg_done=0 immediately; sequence restarts with 0x0D02.
- wrt pulse-width check across all transactions -> wrt never high two consecutive cycles and never high while done is low from a pending transaction.

Source files
------------

// File: rtl/inert_cmd_seq_pkg.sv
// Shared types and command words for the inertial sensor command sequencer.
package inert_pkg;

  typedef enum logic [2:0] {
    PWR_WAIT,
    W1,
    W2,
    W3,
    IDLE,
    RDL,
    RDH
  } state_t;

  localparam logic [15:0] CMD_INT_EN   = 16'h0D02;
  localparam logic [15:0] CMD_GYRO_ODR = 16'h1160;
  localparam logic [15:0] CMD_GYRO_RND = 16'h1440;
  localparam logic [15:0] CMD_YAWL     = 16'hA600;
  localparam logic [15:0] CMD_YAWH     = 16'hA700;

endpackage

// File: rtl/inert_cmd_seq_sync2.sv
// Two-flop synchronizer bringing the asynchronous sensor interrupt into clk.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops give metastability time to resolve
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/inert_cmd_seq.sv
// Inertial sensor command sequencer: configures the sensor after power-up,
// then reads the yaw-rate bytes on every data-ready interrupt.
module inert_cmd_seq #(
  parameter bit FAST_SIM = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic [15:0] yaw_rt,
  output logic        vld,
  output logic        cfg_done
);

  import inert_pkg::*;

  state_t      state;
  state_t      nxt_state;
  logic [15:0] timer;
  logic [7:0]  yaw_lo;
  logic        int_s;
  logic        pwr_ok;
  logic        cap_lo;
  logic        cap_yaw;
  logic        set_cfg;

  sync2 u_int_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (INT),
    .q     (int_s)
  );

  assign pwr_ok = FAST_SIM ? (&timer[8:0]) : (&timer);

  // Free-running power-up timer; only consulted while waiting after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) timer <= 16'h0000;
    else        timer <= timer + 16'd1;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= PWR_WAIT;
    else        state <= nxt_state;
  end

  // Next-state logic; wrt fires on the cycle an issue state is left
  always_comb begin
    nxt_state = state;
    wrt       = 1'b0;
    cap_lo    = 1'b0;
    cap_yaw   = 1'b0;
    set_cfg   = 1'b0;
    case (state)
      PWR_WAIT: if (pwr_ok) begin nxt_state = W1;   wrt = 1'b1; end
      W1:       if (done)   begin nxt_state = W2;   wrt = 1'b1; end
      W2:       if (done)   begin nxt_state = W3;   wrt = 1'b1; end
      W3:       if (done)   begin nxt_state = IDLE; set_cfg = 1'b1; end
      IDLE:     if (int_s)  begin nxt_state = RDL;  wrt = 1'b1; end
      RDL:      if (done)   begin nxt_state = RDH;  wrt = 1'b1; cap_lo = 1'b1; end
      RDH:      if (done)   begin nxt_state = IDLE; cap_yaw = 1'b1; end
      default:  nxt_state = PWR_WAIT;
    endcase
  end

  // Command word is a pure function of the state that issues it
  always_comb begin
    cmd = 16'h0000;
    case (state)
      PWR_WAIT: cmd = CMD_INT_EN;
      W1:       cmd = CMD_GYRO_ODR;
      W2:       cmd = CMD_GYRO_RND;
      IDLE:     cmd = CMD_YAWL;
      RDL:      cmd = CMD_YAWH;
      default:  cmd = 16'h0000;
    endcase
  end

  // Capture the read bytes, publish the yaw rate with its strobe, latch cfg_done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      yaw_lo   <= 8'h00;
      yaw_rt   <= 16'h0000;
      vld      <= 1'b0;
      cfg_done <= 1'b0;
    end else begin
      vld <= cap_yaw;
      if (cap_lo)  yaw_lo   <= rd_data[7:0];
      if (cap_yaw) yaw_rt   <= {rd_data[7:0], yaw_lo};
      if (set_cfg) cfg_done <= 1'b1;
    end
  end

endmodule
